// File: rtl/lcd_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sprite_ctrl
// Purpose  : Overlays a SPR_W x SPR_H sprite ROM on the LCD pixel stream.
//            Owns the sprite position and bounces it around the active area,
//            moving once every FRAME_DIV vertical syncs. Generates a registered
//            ROM read address/enable and a hit flag aligned with ROM data.
// Ports    : pclk, rst             - pixel clock, sync active-high reset
//            en                    - overlay enable, sampled on lcd_vs rise
//            lcd_vs                - vertical sync from timing generator
//            pixel_row/pixel_line  - current pixel x / y coordinate
//            h_disp/v_disp         - active display width / height
//            rom_addr, rom_en      - registered ROM read address / enable
//            sprite_hit            - ROM data valid for current pixel
//            spr_x, spr_y          - current sprite top-left position
//            frame_tick            - pulse in the cycle a move is applied
// Revision : 1.0  initial release
// ============================================================================
module lcd_sprite_ctrl #(
    parameter int SPR_W     = 30,
    parameter int SPR_H     = 30,
    parameter int AW        = 10,
    parameter int X0        = 200,
    parameter int Y0        = 100,
    parameter int STEP_X    = 2,
    parameter int STEP_Y    = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          en,
    input  logic          lcd_vs,
    input  logic [10:0]   pixel_row,
    input  logic [10:0]   pixel_line,
    input  logic [10:0]   h_disp,
    input  logic [10:0]   v_disp,
    output logic [AW-1:0] rom_addr,
    output logic          rom_en,
    output logic          sprite_hit,
    output logic [10:0]   spr_x,
    output logic [10:0]   spr_y,
    output logic          frame_tick
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam int               c_cnt_w    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(FRAME_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [11:0]      c_spr_w    = 12'(SPR_W);
    localparam logic [11:0]      c_spr_h    = 12'(SPR_H);
    localparam logic [11:0]      c_step_x   = 12'(STEP_X);
    localparam logic [11:0]      c_step_y   = 12'(STEP_Y);

    logic [1:0]         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic               r_vs_d;
    logic               w_vs_rise;
    logic [10:0]        r_x, r_y;
    logic               r_dir_x, r_dir_y;      // 1 = moving toward larger coordinate
    logic [11:0]        w_move_x, w_move_y;    // {new_dir, new_pos}
    logic [11:0]        w_row, w_line, w_x, w_y, w_dx, w_dy;
    logic               w_hit;
    logic [AW-1:0]      w_addr;
    logic               r_rom_en, r_sprite_hit;
    logic [AW-1:0]      r_rom_addr;

    // One bouncing axis step. All arithmetic is 12-bit so that pos+step and
    // disp-size can never wrap before the compare. Returns {dir, pos}.
    function automatic logic [11:0] f_move(
        input logic [10:0] pos,
        input logic        dir_pos,
        input logic [10:0] disp,
        input logic [11:0] size,
        input logic [11:0] step
    );
        logic [11:0] p, lim, sum, res;
        p   = {1'b0, pos};
        lim = {1'b0, disp} - size;
        sum = p + step;
        res = {dir_pos, 11'd0};
        if ({1'b0, disp} <= size) begin
            res = {dir_pos, 11'd0};               // sprite does not fit: pin to 0
        end else if (dir_pos) begin
            if (sum >= lim) res = {1'b0, 11'(lim)};
            else            res = {1'b1, 11'(sum)};
        end else begin
            if (p <= step)  res = {1'b1, 11'd0};
            else            res = {1'b0, 11'(p - step)};
        end
        return res;
    endfunction

    assign w_vs_rise = lcd_vs & ~r_vs_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_vs_d      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_vs_d      <= lcd_vs;
        end
    end

    // A vs rise landing in UPDATE is dropped: UPDATE always returns to ACTIVE.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise && en) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_vs_rise) begin
                    if (!en) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_frame_cnt == c_div_last) begin
                        w_state_nxt     = S_UPDATE;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_cnt_one;
                    end
                end
            end
            S_UPDATE: w_state_nxt = S_ACTIVE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_move_x = f_move(r_x, r_dir_x, h_disp, c_spr_w, c_step_x);
    assign w_move_y = f_move(r_y, r_dir_y, v_disp, c_spr_h, c_step_y);

    // Position only moves in the cycle after vs, so a frame never tears.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_x     <= 11'(X0);
            r_y     <= 11'(Y0);
            r_dir_x <= 1'b1;
            r_dir_y <= 1'b1;
        end else if (r_state == S_UPDATE) begin
            {r_dir_x, r_x} <= w_move_x;
            {r_dir_y, r_y} <= w_move_y;
        end
    end

    assign w_row  = {1'b0, pixel_row};
    assign w_line = {1'b0, pixel_line};
    assign w_x    = {1'b0, r_x};
    assign w_y    = {1'b0, r_y};
    assign w_dx   = w_row - w_x;
    assign w_dy   = w_line - w_y;

    assign w_hit = (r_state != S_IDLE)
                 && (w_row  >= w_x) && (w_row  < w_x + c_spr_w)
                 && (w_line >= w_y) && (w_line < w_y + c_spr_h);

    // Address computed modulo 2**AW, which equals truncating the full value.
    assign w_addr = AW'(w_dx) + AW'(SPR_W) * AW'(w_dy);

    // ROM has one cycle of read latency, so sprite_hit trails rom_en by one.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_rom_en     <= 1'b0;
            r_rom_addr   <= '0;
            r_sprite_hit <= 1'b0;
        end else begin
            r_rom_en     <= w_hit;
            r_rom_addr   <= w_hit ? w_addr : '0;
            r_sprite_hit <= r_rom_en;
        end
    end

    assign rom_en     = r_rom_en;
    assign rom_addr   = r_rom_addr;
    assign sprite_hit = r_sprite_hit;
    assign spr_x      = r_x;
    assign spr_y      = r_y;
    assign frame_tick = (r_state == S_UPDATE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_sprite_ctrl
// Purpose  : Self-checking bench for lcd_sprite_ctrl. Two instances share the
//            inputs (FRAME_DIV=1 and FRAME_DIV=3); a behavioural model tracks
//            enable state, frame division and bouncing position per instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_sprite_ctrl;

    logic        pclk, rst, en, lcd_vs;
    logic [10:0] pixel_row, pixel_line, h_disp, v_disp;

    logic [9:0]  a_rom_addr, b_rom_addr;
    logic        a_rom_en, b_rom_en, a_sprite_hit, b_sprite_hit;
    logic [10:0] a_spr_x, a_spr_y, b_spr_x, b_spr_y;
    logic        a_frame_tick, b_frame_tick;

    int n_chk = 0;
    int n_err = 0;
    int tick_a = 0;
    int tick_b = 0;

    // Behavioural model, index 0 = FRAME_DIV 1, index 1 = FRAME_DIV 3
    int mx[2], my[2], mcnt[2];
    bit mdx[2], mdy[2], mact[2];
    int mdiv[2] = '{1, 3};

    lcd_sprite_ctrl #(.FRAME_DIV(1)) u_dut_a (
        .pclk(pclk), .rst(rst), .en(en), .lcd_vs(lcd_vs),
        .pixel_row(pixel_row), .pixel_line(pixel_line),
        .h_disp(h_disp), .v_disp(v_disp),
        .rom_addr(a_rom_addr), .rom_en(a_rom_en), .sprite_hit(a_sprite_hit),
        .spr_x(a_spr_x), .spr_y(a_spr_y), .frame_tick(a_frame_tick)
    );

    lcd_sprite_ctrl #(.FRAME_DIV(3)) u_dut_b (
        .pclk(pclk), .rst(rst), .en(en), .lcd_vs(lcd_vs),
        .pixel_row(pixel_row), .pixel_line(pixel_line),
        .h_disp(h_disp), .v_disp(v_disp),
        .rom_addr(b_rom_addr), .rom_en(b_rom_en), .sprite_hit(b_sprite_hit),
        .spr_x(b_spr_x), .spr_y(b_spr_y), .frame_tick(b_frame_tick)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (a_frame_tick === 1'b1) tick_a++;
        if (b_frame_tick === 1'b1) tick_b++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 200; my[i] = 100; mdx[i] = 1; mdy[i] = 1;
            mcnt[i] = 0; mact[i] = 0;
        end
    endfunction

    function automatic void axis_move(inout int p, inout bit d, input int disp,
                                      input int size, input int step);
        int lim;
        if (disp <= size) begin
            p = 0;
        end else begin
            lim = disp - size;
            if (d) begin
                if (p + step >= lim) begin p = lim; d = 0; end
                else p = p + step;
            end else begin
                if (p <= step) begin p = 0; d = 1; end
                else p = p - step;
            end
        end
    endfunction

    // Apply one vs rise to instance i; returns the number of moves expected.
    function automatic int model_vs(input int i, input bit en_v);
        int moved = 0;
        if (!mact[i]) begin
            if (en_v) mact[i] = 1;
        end else if (!en_v) begin
            mact[i] = 0;
        end else if (mcnt[i] == mdiv[i] - 1) begin
            mcnt[i] = 0;
            axis_move(mx[i], mdx[i], int'(h_disp), 30, 2);
            axis_move(my[i], mdy[i], int'(v_disp), 30, 1);
            moved = 1;
        end else begin
            mcnt[i] = mcnt[i] + 1;
        end
        return moved;
    endfunction

    task automatic vs_pulse(input bit en_v);
        int t0a, t0b, ea, eb;
        t0a = tick_a; t0b = tick_b;
        en = en_v;
        lcd_vs = 1'b1;
        @(posedge pclk); #1;
        lcd_vs = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        ea = model_vs(0, en_v);
        eb = model_vs(1, en_v);
        chk("spr_x_a", 32'(a_spr_x), 32'(mx[0]));
        chk("spr_y_a", 32'(a_spr_y), 32'(my[0]));
        chk("tick_a",  32'(tick_a - t0a), 32'(ea));
        chk("spr_x_b", 32'(b_spr_x), 32'(mx[1]));
        chk("spr_y_b", 32'(b_spr_y), 32'(my[1]));
        chk("tick_b",  32'(tick_b - t0b), 32'(eb));
    endtask

    task automatic hit_chk(input int row, input int line);
        bit hit;
        int addr;
        pixel_row  = 11'(row);
        pixel_line = 11'(line);
        hit = mact[0] && row >= mx[0] && row < mx[0] + 30 &&
              line >= my[0] && line < my[0] + 30;
        addr = hit ? ((row - mx[0]) + 30 * (line - my[0])) % 1024 : 0;
        @(posedge pclk); #1;
        chk("rom_en",   32'(a_rom_en), 32'(hit));
        chk("rom_addr", 32'(a_rom_addr), 32'(addr));
        @(posedge pclk); #1;
        chk("sprite_hit", 32'(a_sprite_hit), 32'(hit));
    endtask

    function automatic int near(input int c);
        int v;
        v = c + $urandom_range(0, 44) - 7;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        return v;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; lcd_vs = 1'b0;
        pixel_row = '0; pixel_line = '0;
        h_disp = 11'd800; v_disp = 11'd480;
        model_reset();
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_spr_x", 32'(a_spr_x), 32'd200);
        chk("rst_spr_y", 32'(a_spr_y), 32'd100);
        chk("rst_rom_en", 32'(a_rom_en), 32'd0);
        chk("rst_rom_addr", 32'(a_rom_addr), 32'd0);
        chk("rst_sprite_hit", 32'(a_sprite_hit), 32'd0);
        chk("rst_frame_tick", 32'(a_frame_tick), 32'd0);

        // Idle: no overlay before activation
        hit_chk(215, 103);

        // Activate, then a directed hit at the initial position
        vs_pulse(1'b1);
        pixel_row = 11'd215; pixel_line = 11'd103;
        @(posedge pclk); #1;
        chk("dir_rom_en", 32'(a_rom_en), 32'd1);
        chk("dir_rom_addr", 32'(a_rom_addr), 32'd105);
        @(posedge pclk); #1;
        chk("dir_sprite_hit", 32'(a_sprite_hit), 32'd1);
        hit_chk(230, 103);
        hit_chk(229, 129);
        hit_chk(199, 100);

        // First move
        vs_pulse(1'b1);
        chk("move_x", 32'(a_spr_x), 32'd202);
        chk("move_y", 32'(a_spr_y), 32'd101);

        // Right-edge bounce and the left-edge mirror case
        h_disp = 11'd234;           // xmax 204
        vs_pulse(1'b1);
        vs_pulse(1'b1);
        h_disp = 11'd31;            // xmax 1
        vs_pulse(1'b1);
        vs_pulse(1'b1);
        vs_pulse(1'b1);
        h_disp = 11'd800;

        // Disable / freeze / resume
        vs_pulse(1'b0);
        hit_chk(mx[0] + 3, my[0] + 3);
        vs_pulse(1'b0);
        vs_pulse(1'b1);
        hit_chk(mx[0] + 3, my[0] + 3);
        vs_pulse(1'b1);

        // Randomized frames with mixed display sizes and enables
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 4))
                0: h_disp = 11'd800;
                1: h_disp = 11'd234;
                2: h_disp = 11'd31;
                3: h_disp = 11'd20;
                default: h_disp = 11'($urandom_range(0, 1200));
            endcase
            case ($urandom_range(0, 4))
                0: v_disp = 11'd480;
                1: v_disp = 11'd132;
                2: v_disp = 11'd31;
                3: v_disp = 11'd20;
                default: v_disp = 11'($urandom_range(0, 800));
            endcase
            vs_pulse($urandom_range(0, 3) != 0);
            for (int k = 0; k < 3; k++) hit_chk(near(mx[0]), near(my[0]));
        end

        // Reset landing in the UPDATE cycle
        h_disp = 11'd800; v_disp = 11'd480;
        vs_pulse(1'b1);
        en = 1'b1;
        lcd_vs = 1'b1;
        @(posedge pclk); #1;
        chk("upd_frame_tick", 32'(a_frame_tick), 32'd1);
        rst = 1'b1; lcd_vs = 1'b0;
        @(posedge pclk); #1;
        chk("rstupd_frame_tick", 32'(a_frame_tick), 32'd0);
        chk("rstupd_spr_x", 32'(a_spr_x), 32'd200);
        chk("rstupd_spr_y", 32'(a_spr_y), 32'd100);
        rst = 1'b0;
        model_reset();
        hit_chk(215, 103);

        // Display narrower than the sprite pins x to 0
        h_disp = 11'd20;
        vs_pulse(1'b1);
        vs_pulse(1'b1);
        chk("narrow_x", 32'(a_spr_x), 32'd0);
        vs_pulse(1'b1);
        chk("narrow_x2", 32'(a_spr_x), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
